mc10_bank_ram: RTL

- Parametrised banked RAM expansion for the MC-10 expansion connector; successor to the fixed 4K internal RAM decode.
- Maps a 2^WIN_LOG2-byte CPU window onto 2^BANK_BITS banks of an external synchronous RAM.
- Provides a bank/control register at REG_ADDR.
- Drives exp_sel/exp_din into the system data-bus OR; detects E-clock phases in the clk_sys domain and issues exactly one RAM write per CPU write cycle.

---
 rtl/mc10_pkg.sv | 9 +
 rtl/mc10_e_sync.sv | 53 +++++
 rtl/mc10_bank_ram.sv | 79 +++++++
 3 files changed

// File: rtl/mc10_pkg.sv
// mc10_pkg: MC-10 memory map constants and bank register bit positions
package mc10_pkg;
  localparam logic [15:0] WIN_BASE_DEF = 16'h5000;
  localparam logic [15:0] REG_ADDR_DEF = 16'hBF80;
  localparam logic [15:0] INT_RAM_BASE = 16'h4000;
  localparam logic [15:0] ROM_BASE = 16'hE000;
  localparam int REG_WP = 6;
  localparam int REG_LOCK = 7;
endpackage

// File: rtl/mc10_e_sync.sv
// mc10_e_sync: E falling-edge detect, bus-cycle capture and one-shot write commit
module mc10_e_sync #(
  parameter int AW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_e,
  input  logic          i_rw,
  input  logic          i_win,
  input  logic          i_reg,
  input  logic [AW-1:0] i_addr,
  input  logic [7:0]    i_data,
  output logic [AW-1:0] o_addr,
  output logic [7:0]    o_data,
  output logic          o_win,
  output logic          o_reg,
  output logic          o_commit
);
  logic          r_e_q, r_armed, r_rw, r_win, r_reg, r_commit;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_data;
  logic          w_fall;
  assign w_fall = r_e_q & ~i_e;
  // capture only after E has been seen low since reset, so a cycle cut by reset never commits
  always_ff @(posedge clk) begin
    if (rst) begin
      r_e_q <= 1'b0;
      r_armed <= 1'b0;
      r_rw <= 1'b1;
      r_win <= 1'b0;
      r_reg <= 1'b0;
      r_addr <= '0;
      r_data <= '0;
      r_commit <= 1'b0;
    end else begin
      r_e_q <= i_e;
      r_armed <= r_armed | ~i_e;
      r_commit <= w_fall & ~r_rw;
      if (i_e & r_armed) begin
        r_rw <= i_rw;
        r_win <= i_win;
        r_reg <= i_reg;
        r_addr <= i_addr;
        r_data <= i_data;
      end
    end
  end
  assign o_addr = r_addr;
  assign o_data = r_data;
  assign o_win = r_win;
  assign o_reg = r_reg;
  assign o_commit = r_commit;
endmodule

// File: rtl/mc10_bank_ram.sv
// mc10_bank_ram: banked external RAM window with bank/write-protect/lock register for the MC-10 bus
module mc10_bank_ram
  import mc10_pkg::*;
#(
  parameter logic [15:0] WIN_BASE = WIN_BASE_DEF,
  parameter int WIN_LOG2 = 12,
  parameter int BANK_BITS = 3,
  parameter logic [15:0] REG_ADDR = REG_ADDR_DEF
) (
  input  logic                          clk_sys,
  input  logic                          reset,
  input  logic [15:0]                   exp_addr,
  input  logic [7:0]                    exp_dout,
  input  logic                          exp_rw,
  input  logic                          exp_e,
  output logic [7:0]                    exp_din,
  output logic                          exp_sel,
  output logic [WIN_LOG2+BANK_BITS-1:0] mem_addr,
  output logic [7:0]                    mem_wdata,
  output logic                          mem_we,
  input  logic [7:0]                    mem_rdata,
  output logic [BANK_BITS-1:0]          bank
);
  localparam int MEM_AW = WIN_LOG2 + BANK_BITS;
  logic [BANK_BITS-1:0] r_bank;
  logic                 r_wp, r_lock;
  logic [7:0]           r_din;
  logic                 w_win_hit, w_reg_hit, w_commit, w_cap_win, w_cap_reg, w_reg_we;
  logic [WIN_LOG2-1:0]  w_cap_addr;
  logic [7:0]           w_cap_data, w_reg_val;
  logic [MEM_AW-1:0]    w_mem_addr;
  assign w_win_hit = exp_addr[15:WIN_LOG2] == WIN_BASE[15:WIN_LOG2];
  assign w_reg_hit = exp_addr == REG_ADDR;
  mc10_e_sync #(.AW(WIN_LOG2)) u_sync (
    .clk(clk_sys),
    .rst(reset),
    .i_e(exp_e),
    .i_rw(exp_rw),
    .i_win(w_win_hit),
    .i_reg(w_reg_hit),
    .i_addr(exp_addr[WIN_LOG2-1:0]),
    .i_data(exp_dout),
    .o_addr(w_cap_addr),
    .o_data(w_cap_data),
    .o_win(w_cap_win),
    .o_reg(w_cap_reg),
    .o_commit(w_commit)
  );
  assign w_reg_we = w_commit & w_cap_reg & ~w_cap_win & ~r_lock;
  assign w_mem_addr = w_commit ? {r_bank, w_cap_addr} : {r_bank, exp_addr[WIN_LOG2-1:0]};
  // readable register image: unimplemented bits read as zero
  always_comb begin
    w_reg_val = '0;
    w_reg_val[BANK_BITS-1:0] = r_bank;
    w_reg_val[REG_WP] = r_wp;
    w_reg_val[REG_LOCK] = r_lock;
  end
  // bank register takes committed writes until lock is set
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      r_bank <= '0;
      r_wp <= 1'b0;
      r_lock <= 1'b0;
    end else if (w_reg_we) begin
      r_bank <= w_cap_data[BANK_BITS-1:0];
      r_wp <= w_cap_data[REG_WP];
      r_lock <= w_cap_data[REG_LOCK];
    end
  end
  // registered bus read data, zero when not reading this device
  always_ff @(posedge clk_sys)
    r_din <= reset ? 8'h00 : (w_win_hit & exp_rw) ? mem_rdata : (w_reg_hit & exp_rw) ? w_reg_val : 8'h00;
  assign exp_sel = w_win_hit | w_reg_hit;
  assign exp_din = r_din;
  assign mem_addr = w_mem_addr;
  assign mem_wdata = w_cap_data;
  assign mem_we = w_commit & w_cap_win & ~r_wp;
  assign bank = r_bank;
endmodule
